// File: rtl/ram_fifo_pkg.sv
// ram_fifo_pkg: shared constants for ram_fifo_ctrl.
//   fifo_depth() - RAM depth derived from the address width.
//   RAM_OP_*     - encoding of the single RAM access made each cycle.
//                  It is used to steer the RAM port and is handy when
//                  probing the controller in waveforms.
package ram_fifo_pkg;

   localparam logic [1:0] RAM_OP_IDLE  = 2'd0;
   localparam logic [1:0] RAM_OP_READ  = 2'd1;
   localparam logic [1:0] RAM_OP_WRITE = 2'd2;

   function automatic int unsigned fifo_depth(input int unsigned addr_width);
      return 32'd1 << addr_width;
   endfunction

endpackage : ram_fifo_pkg

// File: rtl/ram_fifo_ctrl.sv
// ram_fifo_ctrl: valid/ready FIFO controller in front of a single-port RAM
// with a registered read address (read data appears the cycle after issue).
// At most one RAM access per cycle; reads take priority over writes.
// Capacity is DEPTH+1 words: the RAM plus the output register.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   s_valid/s_data/s_ready write stream in
//   m_valid/m_data/m_ready read stream out (registered)
//   ram_we/ram_addr/ram_wdata  RAM command (combinational)
//   ram_rdata             RAM read data
//   count                 occupancy; present only with RAM_FIFO_COUNT_EN
//
// Build option: define RAM_FIFO_COUNT_EN to add the count port.
module ram_fifo_ctrl
   import ram_fifo_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 11
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  s_valid,
   input  logic [DATA_WIDTH-1:0] s_data,
   output logic                  s_ready,
   output logic                  m_valid,
   output logic [DATA_WIDTH-1:0] m_data,
   input  logic                  m_ready,
   output logic                  ram_we,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic [DATA_WIDTH-1:0] ram_wdata,
   input  logic [DATA_WIDTH-1:0] ram_rdata
`ifdef RAM_FIFO_COUNT_EN
   ,
   output logic [ADDR_WIDTH:0]   count
`endif
);

   localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(fifo_depth(ADDR_WIDTH));

   logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_WIDTH:0]   mem_cnt_q, mem_cnt_d;
   logic                  rd_pend_q, rd_pend_d;
   logic                  out_valid_q, out_valid_d;
   logic [DATA_WIDTH-1:0] out_data_q, out_data_d;

   logic       rd_go, wr_go;
   logic [1:0] ram_op;

   // A read may issue only when its data has somewhere to land two cycles
   // later: the output register is empty or is being drained this cycle.
   always_comb begin
      rd_go   = !rd_pend_q && (mem_cnt_q != '0) && (!out_valid_q || m_ready);
      s_ready = rst_n && (mem_cnt_q != DEPTH_C) && !rd_go;
      wr_go   = s_valid && s_ready;
      ram_op  = rd_go ? RAM_OP_READ : (wr_go ? RAM_OP_WRITE : RAM_OP_IDLE);
   end

   assign ram_we    = (ram_op == RAM_OP_WRITE);
   assign ram_addr  = (ram_op == RAM_OP_READ) ? rd_ptr_q : wr_ptr_q;
   assign ram_wdata = s_data;

   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      mem_cnt_d   = mem_cnt_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      // rd_go already requires !rd_pend_q, so the flag lives exactly one cycle.
      rd_pend_d   = rd_go;

      // The RAM slot is released at issue; the word is then owned by the
      // in-flight read and the output register.
      if (rd_go) begin
         rd_ptr_d  = rd_ptr_q + ADDR_WIDTH'(1);
         mem_cnt_d = mem_cnt_q - (ADDR_WIDTH+1)'(1);
      end else if (wr_go) begin
         wr_ptr_d  = wr_ptr_q + ADDR_WIDTH'(1);
         mem_cnt_d = mem_cnt_q + (ADDR_WIDTH+1)'(1);
      end

      // Returning data always finds the output register free: issue was
      // gated on it being empty or consumed in the issue cycle.
      if (rd_pend_q) begin
         out_valid_d = 1'b1;
         out_data_d  = ram_rdata;
      end else if (out_valid_q && m_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         mem_cnt_q   <= '0;
         rd_pend_q   <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         mem_cnt_q   <= mem_cnt_d;
         rd_pend_q   <= rd_pend_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
      end
   end

   assign m_valid = out_valid_q;
   assign m_data  = out_data_q;

`ifdef RAM_FIFO_COUNT_EN
   assign count = mem_cnt_q + (ADDR_WIDTH+1)'(rd_pend_q) + (ADDR_WIDTH+1)'(out_valid_q);
`endif

endmodule : ram_fifo_ctrl

// File: tb/tb_ram_fifo_ctrl.sv
// tb_ram_fifo_ctrl: bench for ram_fifo_ctrl with DEPTH 4 and a behavioural
// registered-address RAM. A queue holds every accepted word in order; each
// output handshake must deliver the queue head. Directed cases cover reset,
// latency, full/back-pressure, drain rate, read/write collision and reset
// with a read in flight, followed by a randomized phase.
module tb_ram_fifo_ctrl;

   localparam int DW    = 8;
   localparam int AW    = 2;
   localparam int DEPTH = 4;
   localparam int CAP   = DEPTH + 1;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          s_valid, s_ready, m_valid, m_ready, ram_we;
   logic [DW-1:0] s_data, m_data, ram_wdata, ram_rdata;
   logic [AW-1:0] ram_addr;
`ifdef RAM_FIFO_COUNT_EN
   logic [AW:0]   count;
`endif

   ram_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clk(clk), .rst_n(rst_n),
      .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
      .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
      .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
      .ram_rdata(ram_rdata)
`ifdef RAM_FIFO_COUNT_EN
      , .count(count)
`endif
   );

   always #5 clk = ~clk;

   // Single-port RAM, address registered, read data from the registered address.
   logic [DW-1:0] ram_mem [DEPTH];
   logic [AW-1:0] ram_addr_r;
   always @(posedge clk) begin
      if (ram_we) ram_mem[ram_addr] <= ram_wdata;
      ram_addr_r <= ram_addr;
   end
   assign ram_rdata = ram_mem[ram_addr_r];

   int n_tests = 0;
   int n_fail  = 0;
   logic [DW-1:0] q[$];
   int wr_total, pop_cnt, cyc_n;
   logic hold_prev;
   logic [DW-1:0] hold_data;
   int pops[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   // Sample at the falling edge: scoreboard the handshakes that the next
   // rising edge will complete.
   task automatic smp();
      logic [DW-1:0] exp_d;
      @(negedge clk);
      cyc_n++;
      if (rst_n) begin
`ifdef RAM_FIFO_COUNT_EN
         chk("count", 32'(count), q.size());
`endif
         if (q.size() == CAP) chk("full_sready", 32'(s_ready), 0);
         if (hold_prev && m_valid) chk("m_hold", 32'(m_data), 32'(hold_data));
         if (m_valid && m_ready) begin
            chk("pop_nonempty", 32'(q.size() != 0), 1);
            if (q.size() != 0) begin
               exp_d = q.pop_front();
               chk("m_data", 32'(m_data), 32'(exp_d));
               pop_cnt++;
            end
         end
         if (s_valid && s_ready) begin
            chk("wr_addr", 32'(ram_addr), wr_total % DEPTH);
            chk("wr_we", 32'(ram_we), 1);
            q.push_back(s_data);
            wr_total++;
         end
         hold_prev = m_valid && !m_ready;
         hold_data = m_data;
      end
   endtask

   task automatic adv();
      @(posedge clk);
      #1;
   endtask

   task automatic step();
      smp();
      adv();
   endtask

   task automatic drain(input int max_cyc);
      s_valid = 1'b0;
      m_ready = 1'b1;
      for (int i = 0; i < max_cyc && q.size() != 0; i++) step();
      chk("drained", q.size(), 0);
      step();
   endtask

   int accepted, got, sent, base, slotx;
   logic seen_sr;

   initial begin
      rst_n = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
      wr_total = 0; pop_cnt = 0; cyc_n = 0; hold_prev = 1'b0; hold_data = '0;
      #2;
      chk("rst_s_ready", 32'(s_ready), 0);
      chk("rst_ram_we", 32'(ram_we), 0);
      chk("rst_ram_addr", 32'(ram_addr), 0);
      chk("rst_m_valid", 32'(m_valid), 0);
      chk("rst_m_data", 32'(m_data), 0);
`ifdef RAM_FIFO_COUNT_EN
      chk("rst_count", 32'(count), 0);
`endif
      adv(); adv();
      rst_n = 1'b1;
      adv();

      // single word, first-word latency
      m_ready = 1'b1; s_valid = 1'b1; s_data = 8'hA5;
      smp();
      chk("t1_we", 32'(ram_we), 1);
      chk("t1_addr", 32'(ram_addr), 0);
      adv();
      s_valid = 1'b0;
      smp(); chk("t1_lat1", 32'(m_valid), 0); adv();
      smp(); chk("t1_lat2", 32'(m_valid), 0); adv();
      smp(); chk("t1_lat3", 32'(m_valid), 1); chk("t1_data", 32'(m_data), 32'hA5); adv();
      smp(); chk("t1_after", 32'(m_valid), 0); adv();

      // fill with downstream stalled: 5 accepted, 6th held off
      m_ready = 1'b0; accepted = 0;
      for (int w = 1; w <= 6; w++) begin
         s_valid = 1'b1; s_data = DW'(w); got = 0;
         for (int k = 0; k < 8 && got == 0; k++) begin
            smp();
            got = int'(s_ready);
            adv();
         end
         accepted += got;
      end
      chk("t2_accepted", accepted, 5);
      smp();
      chk("t2_sready", 32'(s_ready), 0);
      chk("t2_mvalid", 32'(m_valid), 1);
      chk("t2_head", 32'(m_data), 1);
      adv();
      s_valid = 1'b0;

      // drain from full: in order, one word per two cycles
      m_ready = 1'b1; seen_sr = 1'b0; pops.delete();
      for (int i = 0; i < 30 && q.size() != 0; i++) begin
         base = pop_cnt;
         smp();
         if (pop_cnt != base) pops.push_back(cyc_n);
         if (s_ready) seen_sr = 1'b1;
         adv();
      end
      chk("t3_npops", pops.size(), 5);
      for (int i = 1; i < pops.size(); i++) chk("t3_gap", pops[i] - pops[i-1], 2);
      chk("t3_sready_back", 32'(seen_sr), 1);

      // continuous push/pop of 20 words (pointers wrap five times)
      m_ready = 1'b1; sent = 0; base = pop_cnt;
      s_valid = 1'b1; s_data = 8'h40;
      for (int i = 0; i < 300 && sent < 20; i++) begin
         smp();
         if (s_valid && s_ready) sent++;
         adv();
         if (sent < 20) s_data = DW'(8'h40 + sent);
         else s_valid = 1'b0;
      end
      drain(100);
      chk("t4_sent", sent, 20);
      chk("t4_popped", pop_cnt - base, 20);

      // collision: push while a read is eligible
      m_ready = 1'b1; s_valid = 1'b1; s_data = 8'h77;
      slotx = wr_total % DEPTH;
      smp(); adv();
      s_data = 8'h88;
      smp();
      chk("t5_we", 32'(ram_we), 0);
      chk("t5_sready", 32'(s_ready), 0);
      chk("t5_addr", 32'(ram_addr), slotx);
      adv();
      smp();
      chk("t5_we2", 32'(ram_we), 1);
      chk("t5_addr2", 32'(ram_addr), (slotx + 1) % DEPTH);
      adv();
      s_valid = 1'b0;
      drain(20);

      // reset with a read in flight
      m_ready = 1'b1; s_valid = 1'b1; s_data = 8'h5A;
      smp(); adv();
      s_valid = 1'b0;
      smp(); adv();
      rst_n = 1'b0;
      #1;
      chk("t6_mvalid", 32'(m_valid), 0);
      chk("t6_sready", 32'(s_ready), 0);
`ifdef RAM_FIFO_COUNT_EN
      chk("t6_count", 32'(count), 0);
`endif
      q.delete(); wr_total = 0; hold_prev = 1'b0;
      adv(); adv();
      rst_n = 1'b1;
      adv();
      base = pop_cnt;
      s_valid = 1'b1; s_data = 8'h3C;
      smp();
      chk("t6_addr", 32'(ram_addr), 0);
      adv();
      s_valid = 1'b0;
      drain(20);
      chk("t6_pop", pop_cnt - base, 1);

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         s_valid = 1'($urandom_range(0, 1));
         s_data  = DW'($urandom);
         m_ready = ($urandom_range(0, 3) != 0);
         step();
      end
      drain(100);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_ram_fifo_ctrl
